// File: rtl/pa_pkg.sv
// rtl/pa_pkg.sv - primitive record and queue state shared by assembler and rasterizer
package pa_pkg;

  localparam int IV_DATAWIDTH      = 12;
  localparam int IV_DEPTH_FRACBITS = 12;

  typedef struct packed {
    logic [2:0][1:0][IV_DATAWIDTH-1:0] vertex_pixel;
    logic [2:0][IV_DEPTH_FRACBITS-1:0] vertex_z;
    logic [1:0][IV_DATAWIDTH-1:0]      bb_tl;
    logic [1:0][IV_DATAWIDTH-1:0]      bb_br;
  } primitive_t;

  typedef enum logic {
    PQ_IDLE,
    PQ_PENDING
  } pq_state_t;

endpackage

// File: rtl/prim_fifo_mem.sv
// rtl/prim_fifo_mem.sv - primitive storage array with registered read port
module prim_fifo_mem
  import pa_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  primitive_t    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output primitive_t    rdata
);

  primitive_t mem_q [DEPTH];
  primitive_t rdata_q;
  primitive_t rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // A write landing on the slot being read is forwarded so a fresh head is visible next cycle.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/primitive_queue.sv
// rtl/primitive_queue.sv - buffers assembled primitives and hands them to the rasterizer
module primitive_queue
  import pa_pkg::*;
#(
  parameter int IV_DATAWIDTH      = pa_pkg::IV_DATAWIDTH,
  parameter int IV_DEPTH_FRACBITS = pa_pkg::IV_DEPTH_FRACBITS,
  parameter int DEPTH             = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_start,
  input  logic                                   i_dv,
  input  logic [2:0][1:0][IV_DATAWIDTH-1:0]      i_vertex_pixel,
  input  logic [2:0][IV_DEPTH_FRACBITS-1:0]      i_vertex_z,
  input  logic [1:0][IV_DATAWIDTH-1:0]           i_bb_tl,
  input  logic [1:0][IV_DATAWIDTH-1:0]           i_bb_br,
  input  logic                                   i_finished,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic [2:0][1:0][IV_DATAWIDTH-1:0]      o_vertex_pixel,
  output logic [2:0][IV_DEPTH_FRACBITS-1:0]      o_vertex_z,
  output logic [1:0][IV_DATAWIDTH-1:0]           o_bb_tl,
  output logic [1:0][IV_DATAWIDTH-1:0]           o_bb_br,
  output logic [CW-1:0]                          o_count,
  output logic                                   o_empty,
  output logic                                   o_full,
  output logic                                   o_overflow,
  output logic                                   o_done
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  pq_state_t     state_q, state_d;

  logic       push, pop, push_acc, rd_en, empty, full, done;
  primitive_t wr_prim, rd_prim;

  assign wr_prim = '{vertex_pixel: i_vertex_pixel, vertex_z: i_vertex_z,
                     bb_tl: i_bb_tl, bb_br: i_bb_br};

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign push     = i_dv;
  assign pop      = !empty && i_ready;
  assign push_acc = push && (!full || pop);
  // Head register reloads only when the head changes: a pop, or the first entry into an empty queue.
  assign rd_en    = pop || (push && empty);

  always_comb begin
    wr_ptr_d   = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push_acc && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push_acc && pop) begin
      count_d = count_q - CW'(1);
    end
    overflow_d = (i_start ? 1'b0 : overflow_q) | (push && full && !pop);
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      PQ_IDLE: begin
        if (i_finished) begin
          state_d = PQ_PENDING;
        end
      end
      PQ_PENDING: begin
        if (i_start) begin
          state_d = PQ_IDLE;
        end else if (empty && !push) begin
          state_d = PQ_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = PQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= PQ_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  prim_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push_acc),
    .waddr (wr_ptr_q),
    .wdata (wr_prim),
    .re    (rd_en),
    .raddr (rd_ptr_d),
    .rdata (rd_prim)
  );

  assign o_vertex_pixel = rd_prim.vertex_pixel;
  assign o_vertex_z     = rd_prim.vertex_z;
  assign o_bb_tl        = rd_prim.bb_tl;
  assign o_bb_br        = rd_prim.bb_br;
  assign o_valid        = !empty;
  assign o_count        = count_q;
  assign o_empty        = empty;
  assign o_full         = full;
  assign o_overflow     = overflow_q;
  assign o_done         = done;

endmodule

// File: tb/tb_primitive_queue.sv
// tb/tb_primitive_queue.sv - scoreboard bench for primitive_queue
module tb_primitive_queue;
  import pa_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  typedef logic [159:0] cv_t;

  logic clk = 1'b0;
  logic rst, i_start, i_dv, i_finished, i_ready;
  primitive_t in_p, out_p;
  logic [2:0][1:0][IV_DATAWIDTH-1:0] o_vertex_pixel;
  logic [2:0][IV_DEPTH_FRACBITS-1:0] o_vertex_z;
  logic [1:0][IV_DATAWIDTH-1:0]      o_bb_tl, o_bb_br;
  logic [CW-1:0] o_count;
  logic o_valid, o_empty, o_full, o_overflow, o_done;

  int n_cmp = 0;
  int n_bad = 0;
  int model_cnt = 0;
  primitive_t sb[$];

  always #5 clk = ~clk;

  primitive_queue #(
    .IV_DATAWIDTH(IV_DATAWIDTH), .IV_DEPTH_FRACBITS(IV_DEPTH_FRACBITS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_dv(i_dv),
    .i_vertex_pixel(in_p.vertex_pixel), .i_vertex_z(in_p.vertex_z),
    .i_bb_tl(in_p.bb_tl), .i_bb_br(in_p.bb_br), .i_finished(i_finished),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_vertex_pixel(o_vertex_pixel), .o_vertex_z(o_vertex_z),
    .o_bb_tl(o_bb_tl), .o_bb_br(o_bb_br), .o_count(o_count),
    .o_empty(o_empty), .o_full(o_full), .o_overflow(o_overflow), .o_done(o_done)
  );

  assign out_p = {o_vertex_pixel, o_vertex_z, o_bb_tl, o_bb_br};

  task automatic check_eq(input string tag, input cv_t obs, input cv_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic primitive_t mk(input int x, input int y, input int z);
    primitive_t p;
    p.vertex_pixel[0][0] = IV_DATAWIDTH'(x);
    p.vertex_pixel[0][1] = IV_DATAWIDTH'(y);
    p.vertex_pixel[1][0] = IV_DATAWIDTH'(x + 5);
    p.vertex_pixel[1][1] = IV_DATAWIDTH'(y + 3);
    p.vertex_pixel[2][0] = IV_DATAWIDTH'(x + 2);
    p.vertex_pixel[2][1] = IV_DATAWIDTH'(y + 9);
    p.vertex_z[0]        = IV_DEPTH_FRACBITS'(z);
    p.vertex_z[1]        = IV_DEPTH_FRACBITS'(z + 1);
    p.vertex_z[2]        = IV_DEPTH_FRACBITS'(z + 2);
    p.bb_tl[0]           = IV_DATAWIDTH'(x);
    p.bb_tl[1]           = IV_DATAWIDTH'(y);
    p.bb_br[0]           = IV_DATAWIDTH'(x + 40);
    p.bb_br[1]           = IV_DATAWIDTH'(y + 40);
    return p;
  endfunction

  // One clock: predicts handshake from the bench model, scores the head on pops, then checks occupancy.
  task automatic cycle(output bit popped);
    bit pushed;
    primitive_t exp_p;
    check_eq("valid", cv_t'(o_valid), cv_t'(model_cnt != 0));
    popped = (model_cnt != 0) && i_ready;
    if (popped) begin
      exp_p = sb.pop_front();
      check_eq("head_data", cv_t'(out_p), cv_t'(exp_p));
    end
    pushed = i_dv && ((model_cnt < DEPTH) || popped);
    if (pushed) sb.push_back(in_p);
    model_cnt = model_cnt + int'(pushed) - int'(popped);
    @(posedge clk);
    #1;
    check_eq("count", cv_t'(o_count), cv_t'(model_cnt));
  endtask

  task automatic drain(input bit expect_no_done);
    bit p;
    for (int k = 0; k < 40 && model_cnt != 0; k++) begin
      i_ready = 1'b1;
      cycle(p);
      if (expect_no_done) check_eq("no_done_drain", cv_t'(o_done), cv_t'(0));
    end
    check_eq("drained", cv_t'(model_cnt == 0), cv_t'(1));
  endtask

  initial begin
    bit p;
    int pops, pop5_cyc, pulses;
    rst = 1'b1; i_start = 1'b0; i_dv = 1'b0; i_finished = 1'b0; i_ready = 1'b0;
    in_p = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_count", cv_t'(o_count), cv_t'(0));
    check_eq("rst_valid", cv_t'(o_valid), cv_t'(0));
    check_eq("rst_empty", cv_t'(o_empty), cv_t'(1));
    check_eq("rst_full", cv_t'(o_full), cv_t'(0));
    check_eq("rst_ovf", cv_t'(o_overflow), cv_t'(0));
    check_eq("rst_done", cv_t'(o_done), cv_t'(0));
    check_eq("rst_data", cv_t'(out_p), cv_t'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single primitive, one-cycle latency
    in_p = mk(10, 20, 'h800); i_dv = 1'b1; i_ready = 1'b1;
    cycle(p);
    i_dv = 1'b0;
    check_eq("t1_valid", cv_t'(o_valid), cv_t'(1));
    check_eq("t1_head", cv_t'(out_p), cv_t'(mk(10, 20, 'h800)));
    cycle(p);
    check_eq("t1_popped", cv_t'(p), cv_t'(1));

    // fill to full, then overflow
    i_ready = 1'b0;
    for (int x = 0; x < 16; x++) begin
      in_p = mk(x, 100 + x, 3 * x); i_dv = 1'b1;
      cycle(p);
    end
    check_eq("t2_full", cv_t'(o_full), cv_t'(1));
    check_eq("t2_count16", cv_t'(o_count), cv_t'(16));
    check_eq("t2_ovf0", cv_t'(o_overflow), cv_t'(0));
    in_p = mk(99, 99, 99);
    cycle(p);
    i_dv = 1'b0;
    check_eq("t2_ovf1", cv_t'(o_overflow), cv_t'(1));
    check_eq("t2_full_hold", cv_t'(o_full), cv_t'(1));

    // i_start clears overflow without flushing
    i_start = 1'b1;
    cycle(p);
    i_start = 1'b0;
    check_eq("t3_start_ovf", cv_t'(o_overflow), cv_t'(0));

    // push and pop while full
    in_p = mk(200, 201, 202); i_dv = 1'b1; i_ready = 1'b1;
    cycle(p);
    i_dv = 1'b0;
    check_eq("t3_count16", cv_t'(o_count), cv_t'(16));
    check_eq("t3_ovf0", cv_t'(o_overflow), cv_t'(0));
    drain(1'b0);

    // five pushes, finished on the fifth, ready toggling
    pops = 0; pop5_cyc = -10; pulses = 0;
    for (int c = 0; c < 30; c++) begin
      i_dv       = (c < 5);
      i_finished = (c == 4);
      i_ready    = c[0];
      in_p       = mk(300 + c, 400 + c, 500 + c);
      check_eq("t4_done", cv_t'(o_done), cv_t'(pops == 5 && c == pop5_cyc + 1));
      if (o_done) pulses++;
      cycle(p);
      if (p) begin
        pops++;
        if (pops == 5) pop5_cyc = c;
      end
    end
    i_dv = 1'b0; i_finished = 1'b0;
    check_eq("t4_pops", cv_t'(pops), cv_t'(5));
    check_eq("t4_pulses", cv_t'(pulses), cv_t'(1));

    // finished with empty queue
    i_finished = 1'b1;
    check_eq("t5_done_early", cv_t'(o_done), cv_t'(0));
    cycle(p);
    i_finished = 1'b0;
    check_eq("t5_done_pulse", cv_t'(o_done), cv_t'(1));
    cycle(p);
    check_eq("t5_done_once", cv_t'(o_done), cv_t'(0));

    // i_start while pending cancels done and clears overflow
    i_ready = 1'b0;
    for (int x = 0; x < 17; x++) begin
      in_p = mk(600 + x, x, x); i_dv = 1'b1;
      cycle(p);
    end
    i_dv = 1'b0;
    check_eq("t5_ovf1", cv_t'(o_overflow), cv_t'(1));
    i_finished = 1'b1;
    cycle(p);
    i_finished = 1'b0; i_start = 1'b1;
    check_eq("t5_start_nodone", cv_t'(o_done), cv_t'(0));
    cycle(p);
    i_start = 1'b0;
    check_eq("t5_start_ovf", cv_t'(o_overflow), cv_t'(0));
    drain(1'b1);
    repeat (2) begin
      cycle(p);
      check_eq("t5_no_late_done", cv_t'(o_done), cv_t'(0));
    end

    // asynchronous reset with entries queued
    i_ready = 1'b0;
    for (int x = 0; x < 7; x++) begin
      in_p = mk(700 + x, x, x); i_dv = 1'b1;
      cycle(p);
    end
    i_dv = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_eq("t6_async_count", cv_t'(o_count), cv_t'(0));
    check_eq("t6_async_valid", cv_t'(o_valid), cv_t'(0));
    check_eq("t6_async_empty", cv_t'(o_empty), cv_t'(1));
    check_eq("t6_async_data", cv_t'(out_p), cv_t'(0));
    sb.delete();
    model_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_p = mk(77, 78, 79); i_dv = 1'b1; i_ready = 1'b1;
    cycle(p);
    i_dv = 1'b0;
    drain(1'b0);
    check_eq("t6_only_entry", cv_t'(o_empty), cv_t'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/primitive_queue.md
Name: primitive_queue

Overview:
- Receive end of the primitive assembler's output interface.
- Captures each primitive presented with i_dv: 3 screen-space vertices, 3 depths and a bounding box. That interface has no backpressure.
- Buffers primitives in a FIFO and presents them to the rasterizer front-end over a valid/ready handshake.
- Propagates the assembler's end-of-model pulse as o_done only after every primitive of the model has drained.

Parameters:
- IV_DATAWIDTH, 12, signed pixel/bounding-box coordinate width.
- IV_DEPTH_FRACBITS, 12, unsigned Q0.12 depth width.
- DEPTH, 16, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  start of model; clears o_overflow and the done-pending flag.
- i_dv  in  1  primitive valid; each high cycle is one primitive.
- i_vertex_pixel  in  [3][2]xIV_DATAWIDTH  vertex x,y.
- i_vertex_z  in  [3]xIV_DEPTH_FRACBITS  vertex depths.
- i_bb_tl  in  [2]xIV_DATAWIDTH  bounding box min x,y.
- i_bb_br  in  [2]xIV_DATAWIDTH  bounding box max x,y.
- i_finished  in  1  assembler end-of-model pulse.
- o_valid  out  1  head entry available.
- i_ready  in  1  consumer accepts the head entry.
- o_vertex_pixel, o_vertex_z, o_bb_tl, o_bb_br  out  same widths as inputs  head entry.
- o_count  out  $clog2(DEPTH)+1  occupancy.
- o_empty  out  1  o_count==0.
- o_full  out  1  o_count==DEPTH.
- o_overflow  out  1  sticky: a primitive was dropped.
- o_done  out  1  one-cycle pulse: model drained.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst asserted, including mid-operation, asynchronously clears pointers, o_count=0, o_valid=0, o_empty=1, o_full=0, o_overflow=0, o_done=0 and done_pending.
  - Data outputs read 0 after reset.
  - Storage array contents are not reset.
- Push and pop:
  - push = i_dv; pop = o_valid & i_ready.
  - Entry packs all primitive fields: 6*IV_DATAWIDTH + 3*IV_DEPTH_FRACBITS + 4*IV_DATAWIDTH bits (156 at defaults).
- Latency:
  - A primitive pushed at edge N into an empty queue appears with o_valid=1 after edge N; it is visible in the cycle following the push.
  - No combinational path from i_dv to o_valid.
- Output stability: while o_valid=1 and i_ready=0, all o_* data are held stable.
- Simultaneous push and pop:
  - Allowed at any occupancy, including full; the push is accepted when full only if a pop occurs in the same cycle.
  - o_count is unchanged.
  - Empty with push: no pop is possible, since o_valid=0.
- Overflow: push when o_full=1 and no pop → primitive dropped; o_overflow=1 from the next cycle, held until i_start or rst.
- Pointers: binary, $clog2(DEPTH) bits, wrap modulo DEPTH.
- Done state machine:
  - States: IDLE, PENDING.
  - IDLE → PENDING on i_finished.
  - PENDING → IDLE when o_count==0 and no push this cycle; o_done=1 for exactly that one cycle.
  - i_finished in the same cycle as i_dv: that primitive belongs to the model and must drain before o_done.
  - i_finished while already in PENDING: no effect.
  - i_start in PENDING → IDLE; no o_done is emitted.
  - i_finished with an already-empty queue: o_done pulses one cycle later.
- i_start does not flush queued entries.

Decomposition:
- Shared package pa_pkg holds:
  - typedef primitive_t, a packed struct of the vertex pixel, depth and bounding-box fields;
  - typedef pq_state_t {PQ_IDLE, PQ_PENDING}.
- The same primitive_t is reused by the assembler output and the rasterizer input.
- One sub-module: prim_fifo_mem, a DEPTH x $bits(primitive_t) register array with write-enable and registered read, single clock.
- Pointer, count, overflow and done logic live in primitive_queue.

Test Plan:
- Reset, then one push with v0=(10,20), z=0x800, bb=(10,20)-(50,60), i_ready=1 → o_valid=1 next cycle with identical fields; o_count 1→0 after the pop.
- i_ready=0, 16 consecutive pushes (x = 0..15) → o_full=1, o_count=16, o_overflow=0. A 17th push → o_overflow=1, count stays 16. Drain → x values 0..15 in order, entry 17 is absent.
- Full queue, push and pop in the same cycle → o_count stays 16, o_overflow=0, the new entry emerges last.
- 5 pushes, i_finished in the same cycle as the 5th push, i_ready toggling every other cycle → o_done is a single pulse, in the cycle after the 5th pop completes and never earlier.
- i_finished with an empty queue → o_done pulse exactly one cycle later. i_start asserted while PENDING → no o_done, o_overflow cleared.
- Assert rst mid-stream with 7 entries queued → outputs clear immediately without waiting for clk. After release, a new push is the only entry output.
